// File: rtl/keyemu_pkg.sv
// Shared types and helpers for the 4x4 matrix-keypad emulator.
package keyemu_pkg;

  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned LFSR_W   = 16;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BOUNCE_P = 2'd1,
    HELD     = 2'd2,
    BOUNCE_R = 2'd3
  } keyemu_state_e;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] key);
    return key[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] key);
    return key[1:0];
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Keypad matrix lines plus press/release command port of the keypad emulator.
interface keypad_matrix_emulator_if;
  import keyemu_pkg::*;

  logic [KEY_ROWS-1:0] rows_in;
  logic [KEY_COLS-1:0] cols_out;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_press;
  logic [KEY_W-1:0]    cmd_key;
  logic                contact;
  logic                busy;
  logic                cmd_err;

  // master: scanner / test sequencer side; slave: the emulated keypad
  modport master (
    output rows_in, cmd_valid, cmd_press, cmd_key,
    input  cols_out, cmd_ready, contact, busy, cmd_err
  );

  modport slave (
    input  rows_in, cmd_valid, cmd_press, cmd_key,
    output cols_out, cmd_ready, contact, busy, cmd_err
  );
endinterface

// File: rtl/keyemu_lfsr.sv
// 16-bit Galois LFSR used as the contact-bounce noise source.
module keyemu_lfsr
  import keyemu_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic bit_c
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_d;
    end
  end

  // bit 0 of the value the register takes on this advance
  assign bit_c = lfsr_d[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 keypad model answering scanner row strobes, with scheduled press/release.
// Contact bounce is built only when KEYEMU_BOUNCE_EN is defined; otherwise transitions are clean.
module keypad_matrix_emulator
  import keyemu_pkg::*;
#(
  parameter int unsigned       BOUNCE_CYCLES = 27000,
  parameter int unsigned       TICK_DIV      = 270,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  keypad_matrix_emulator_if.slave  kif
);

`ifdef KEYEMU_BOUNCE_EN
  localparam bit BOUNCE_BUILT = 1'b1;
`else
  localparam bit BOUNCE_BUILT = 1'b0;
`endif

  // a zero divider or zero seed would stall the noise source, so treat as clean
  localparam bit BOUNCE_ON = BOUNCE_BUILT && (BOUNCE_CYCLES != 0) &&
                             (TICK_DIV != 0) && (LFSR_SEED != '0);

  keyemu_state_e    state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             contact_q, contact_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             accept;
  logic             in_bounce;
  logic             tick_c;
  logic             done_c;
  logic             lfsr_bit_c;

  assign in_bounce = (state_q == BOUNCE_P) || (state_q == BOUNCE_R);

`ifdef KEYEMU_BOUNCE_EN
  localparam int unsigned BOUNCE_LAST = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
  localparam int unsigned TICK_LAST   = (TICK_DIV > 1) ? TICK_DIV - 1 : 0;
  localparam int unsigned CNT_W       = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned TICK_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [TICK_W-1:0] tick_q;

  // window and tick counters restart at zero on every bounce entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= '0;
    end else if (!in_bounce) begin
      cnt_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      tick_q <= tick_c ? '0 : tick_q + TICK_W'(1);
    end
  end

  assign tick_c = BOUNCE_ON && in_bounce && (tick_q == TICK_W'(TICK_LAST));
  assign done_c = !BOUNCE_ON || (cnt_q == CNT_W'(BOUNCE_LAST));

  keyemu_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (tick_c),
    .bit_c   (lfsr_bit_c)
  );
`else
  assign tick_c     = 1'b0;
  assign done_c     = 1'b1;
  assign lfsr_bit_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      contact_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    contact_d = contact_q;
    err_d     = 1'b0;
    accept    = kif.cmd_valid && ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (kif.cmd_press) begin
            key_d   = kif.cmd_key;
            state_d = BOUNCE_P;
            if (!BOUNCE_ON) contact_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BOUNCE_P: begin
        if (tick_c) contact_d = lfsr_bit_c;
        if (done_c) begin
          contact_d = 1'b1;
          state_d   = HELD;
        end
      end
      HELD: begin
        if (accept) begin
          if (!kif.cmd_press) begin
            state_d = BOUNCE_R;
            if (!BOUNCE_ON) contact_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BOUNCE_R: begin
        if (tick_c) contact_d = lfsr_bit_c;
        if (done_c) begin
          contact_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE) || (state_d == HELD);
    busy_d  = (state_d == BOUNCE_P) || (state_d == BOUNCE_R);
  end

  // column pulls low only while the held key's row is strobed
  always_comb begin
    kif.cols_out = '1;
    if (contact_q && !kif.rows_in[key_row(key_q)]) begin
      kif.cols_out[key_col(key_q)] = 1'b0;
    end
  end

  assign kif.cmd_ready = ready_q;
  assign kif.contact   = contact_q;
  assign kif.busy      = busy_q;
  assign kif.cmd_err   = err_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed self-checking bench for keypad_matrix_emulator (clean or KEYEMU_BOUNCE_EN build).
module tb_keypad_matrix_emulator;
  import keyemu_pkg::*;

  localparam int unsigned BC   = 20;
  localparam int unsigned TD   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  keypad_matrix_emulator_if kif();

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES (BC),
    .TICK_DIV      (TD),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for ready, present one command, return #1 after the accepting edge
  task automatic issue(input logic press, input logic [3:0] key);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (kif.cmd_ready) break;
    end
    check("issue_ready", 16'(kif.cmd_ready), 16'h1);
    kif.cmd_valid = 1'b1;
    kif.cmd_press = press;
    kif.cmd_key   = key;
    step();
    kif.cmd_valid = 1'b0;
  endtask

  task automatic wait_settled();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (kif.cmd_ready && !kif.busy) break;
    end
    check("settle", 16'({kif.cmd_ready, kif.busy}), 16'b10);
    step();
  endtask

  // async reset must clear outputs in the same cycle; IDLE with ready after release
  task automatic rst_checks(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_cols"}, 16'(kif.cols_out), 16'hF);
    check({tag, "_contact_ready"}, 16'({kif.contact, kif.cmd_ready}), 16'b00);
    step();
    rst = 1'b0;
    step();
    check({tag, "_after"}, 16'({kif.cmd_ready, kif.busy, kif.contact}), 16'b100);
  endtask

  task automatic idle_release_err(input string tag);
    issue(1'b0, 4'd5);
    check({tag, "_err"}, 16'({kif.cmd_err, kif.cmd_ready, kif.busy}), 16'b110);
    step();
    check({tag, "_err_clr"}, 16'(kif.cmd_err), 16'h0);
  endtask

`ifdef KEYEMU_BOUNCE_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // press key 3 on row 0 with the LFSR at its seed and follow the bounce
  task automatic run_bounce(input string tag);
    logic [15:0] m;
    logic        cont;
    int unsigned t;
    logic [3:0]  exp_cols;
    m    = SEED;
    cont = 1'b0;
    t    = 0;
    kif.rows_in = 4'b1110;
    issue(1'b1, 4'd3);
    for (int j = 0; j < int'(BC); j++) begin
      if (j == 4) begin
        kif.cmd_valid = 1'b1;
        kif.cmd_press = 1'b0;
      end
      if (j == 10) kif.cmd_valid = 1'b0;
      @(negedge clk);
      exp_cols = cont ? 4'b0111 : 4'b1111;
      check({tag, "_bounce"}, 16'({kif.cmd_ready, kif.busy, kif.cmd_err, kif.cols_out}),
            16'({1'b0, 1'b1, 1'b0, exp_cols}));
      if (t == TD - 1) begin
        m    = lfsr_step(m);
        cont = m[0];
        t    = 0;
      end else begin
        t++;
      end
      if (j == int'(BC) - 1) cont = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_held"}, 16'({kif.cmd_ready, kif.busy, kif.cols_out}), 16'({2'b10, 4'b0111}));
    end
    step();
  endtask
`endif

  initial begin
    logic [3:0] rows_tab [4];
    logic [3:0] cols_tab [4];
    logic [3:0] v;
    rows_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    cols_tab = '{4'b1111, 4'b1101, 4'b1111, 4'b1111};

    rst           = 1'b1;
    kif.rows_in   = 4'b1111;
    kif.cmd_valid = 1'b0;
    kif.cmd_press = 1'b0;
    kif.cmd_key   = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 16'({kif.contact, kif.busy, kif.cmd_ready, kif.cmd_err}), 16'b0000);
    check("reset_cols", 16'(kif.cols_out), 16'hF);
    step();
    rst = 1'b0;
    step();
    check("post_reset_ready", 16'(kif.cmd_ready), 16'h1);

    idle_release_err("idle_rel1");

`ifndef KEYEMU_BOUNCE_EN
    check("pre_press_contact", 16'(kif.contact), 16'h0);
    issue(1'b1, 4'd5);
    check("press_bp", 16'({kif.contact, kif.busy, kif.cmd_ready}), 16'b110);
    // a command offered while not ready is ignored without error
    kif.cmd_valid = 1'b1;
    kif.cmd_press = 1'b0;
    step();
    kif.cmd_valid = 1'b0;
    check("held_entry", 16'({kif.contact, kif.busy, kif.cmd_ready, kif.cmd_err}), 16'b1010);
    step();
    check("held_stable", 16'({kif.contact, kif.busy, kif.cmd_ready}), 16'b101);

    for (int i = 0; i < 4; i++) begin
      kif.rows_in = rows_tab[i];
      #1;
      check($sformatf("scan_row%0d", i), 16'(kif.cols_out), 16'(cols_tab[i]));
    end
    kif.rows_in = 4'b0101;
    #1;
    check("multi_row", 16'(kif.cols_out), 16'b1101);
    kif.rows_in = 4'b1110;
    #1;
    check("other_row", 16'(kif.cols_out), 16'b1111);

    issue(1'b1, 4'd3);
    check("held_press_err", 16'(kif.cmd_err), 16'h1);
    step();
    check("held_press_err_clr", 16'(kif.cmd_err), 16'h0);
    kif.rows_in = 4'b1101;
    #1;
    check("key_kept_5", 16'(kif.cols_out), 16'b1101);
    kif.rows_in = 4'b1110;
    #1;
    check("key_not_3", 16'(kif.cols_out), 16'b1111);

    issue(1'b0, 4'hA);
    check("release_br", 16'({kif.contact, kif.busy, kif.cmd_ready}), 16'b010);
    step();
    check("release_idle", 16'({kif.contact, kif.busy, kif.cmd_ready}), 16'b001);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      kif.rows_in = v;
      #1;
      check($sformatf("idle_rows_%0d", i), 16'(kif.cols_out), 16'hF);
    end

    kif.rows_in = 4'b1101;
    issue(1'b1, 4'd5);
    check("bp_cols", 16'(kif.cols_out), 16'b1101);
    rst_checks("rst_bp");
    idle_release_err("idle_rel2");

    issue(1'b1, 4'd5);
    wait_settled();
    check("held_cols", 16'(kif.cols_out), 16'b1101);
    rst_checks("rst_held");
`else
    run_bounce("b1");
    issue(1'b1, 4'd5);
    check("held_press_err", 16'(kif.cmd_err), 16'h1);
    step();
    kif.rows_in = 4'b1110;
    #1;
    check("key_kept_3", 16'(kif.cols_out), 16'b0111);
    issue(1'b0, 4'd0);
    wait_settled();
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      kif.rows_in = v;
      #1;
      check($sformatf("idle_rows_%0d", i), 16'(kif.cols_out), 16'hF);
    end

    issue(1'b1, 4'd5);
    repeat (7) step();
    check("mid_bp_busy", 16'(kif.busy), 16'h1);
    rst_checks("rst_bp");
    run_bounce("b2");
    rst_checks("rst_held");
`endif

    idle_release_err("idle_rel3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
